conv_layer_stream: RTL and testbench
====================================

CONV_LAYER_STREAM -- requirements
Module: conv_layer_stream

Interface
REQ-001 Parameter DATA_W, default 8: unsigned input pixel width.
REQ-002 Parameter IMG_W, default 28: pixels per row.
REQ-003 Parameter IMG_H, default 28: rows per frame.
REQ-004 Parameter K, default 5: square kernel size, K >= 2 and K <= IMG_W and K <= IMG_H.
REQ-005 Parameter NUM_FILT, default 6: number of output filters (channels).
REQ-006 Parameter WT_W, default 8: signed weight width.
REQ-007 Parameter OUT_W, default 16: signed output width.
REQ-008 Parameter FRAC_SHIFT, default 8: right shift applied to each accumulator, 0..ACC_W-1.
REQ-009 Clock and reset: one clock; reset is asynchronous and active-high. Ports clk and rst.
REQ-010 clk  in  1  sole clock, all logic rising-edge.
REQ-011 rst  in  1  asynchronous active-high reset.
REQ-012 in_valid  in  1  pixel offered.
REQ-013 in_ready  out  1  block accepts the pixel this cycle.
REQ-014 in_data  in  DATA_W  unsigned pixel, raster order.
REQ-015 wt_we  in  1  weight write strobe.
REQ-016 wt_addr  in  clog2(NUM_FILT*K*K)  index = filt*K*K + row*K + col.
REQ-017 wt_data  in  WT_W  signed weight.
REQ-018 out_valid  out  1  output beat offered.
REQ-019 out_ready  in  1  downstream accepts the beat.
REQ-020 out_data  out  OUT_W  signed feature.
REQ-021 out_chan  out  clog2(NUM_FILT)  filter index of out_data.
REQ-022 out_last  out  1  high on the final channel of the final window of a frame.
REQ-023 busy  out  1  high from the first accepted pixel of a frame until the out_last beat completes.

Function
REQ-024 Transfers complete only on valid&ready; in_ready never depends combinationally on in_valid.
REQ-025 Column and row counters advance per accepted pixel; the column wraps at IMG_W-1, the row wraps at IMG_H-1, and both return to 0 after the last pixel of a frame.
REQ-026 K-1 line buffers of IMG_W entries plus a KxK shift window hold the neighbourhood; a window is complete when row >= K-1 and col >= K-1, giving (IMG_W-K+1)*(IMG_H-K+1) windows per frame.
REQ-027 FSM states: RUN (in_ready=1), MAC (in_ready=0, exactly 2 cycles), EMIT (in_ready=0, out_valid=1).
REQ-028 Transitions: RUN->MAC on an accepted window-completing pixel; MAC->EMIT after 2 cycles; EMIT->RUN on the handshake of channel NUM_FILT-1.
REQ-029 Non-window pixels are accepted back-to-back in RUN.
REQ-030 Arithmetic: each pixel is zero-extended to signed DATA_W+1, multiplied by its weight, and summed over the K*K taps per filter in ACC_W = DATA_W+1+WT_W+clog2(K*K) bits with no overflow.
REQ-031 Output = (acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, with no rounding term when FRAC_SHIFT=0, then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-032 EMIT presents channels 0..NUM_FILT-1 in order; out_data, out_chan and out_last hold stable while out_valid & !out_ready.
REQ-033 Weight writes take effect only when busy=0 and are ignored when busy=1.
REQ-034 Writes of wt_addr >= NUM_FILT*K*K are ignored.
REQ-035 Weights reset to 0.

Reset
REQ-036 rst clears counters, line buffers, window, and weights, and sets the FSM to RUN.
REQ-037 In reset: in_ready=1, out_valid=0, out_data=0, out_chan=0, out_last=0, busy=0.
REQ-038 Reset mid-frame discards partial state; the next accepted pixel is pixel (0,0).

Structure
REQ-039 Package conv_pkg holds the state enum and the ACC_W/clog2 helper functions.
REQ-040 The line buffer plus window is a sub-module, conv_line_buffer.
REQ-041 The MAC array and the FSM stay in conv_layer_stream.

Verification (bench parameters: IMG_W=IMG_H=5, K=3, NUM_FILT=2, FRAC_SHIFT=4, in_valid=1 and out_ready=1 unless stated)
REQ-042 Filter0 centre weight 16, filter1 all weights 16; pixels 0..24 -> 18 beats; ch0 equals the centre pixel (6,7,8,11,...), ch1 equals the 3x3 sum (54 for the first window).
REQ-043 FRAC_SHIFT=0, all pixels 255, all weights 127 -> every beat 32767; with all weights -128 -> every beat -32768.
REQ-044 Only the centre weight of filter0 is 1, FRAC_SHIFT=4, window-centre pixel 8 -> ch0 = 1; centre pixel 7 -> ch0 = 0.
REQ-045 out_ready held low 10 cycles during EMIT -> out_data, out_chan, and out_last stable; in_ready=0 throughout; no beat lost.
REQ-046 rst asserted after 12 pixels, then a full frame -> output identical to a clean-frame run; out_last high only on beat 18; busy falls the cycle after it.
REQ-047 wt_we pulsed while busy=1 -> output unchanged from a run without the pulse; the same write with busy=0 takes effect.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the streaming convolution layer.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MAC  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // $clog2 that never returns 0, so single-entry ranges still get a 1-bit port
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Accumulator width: signed pixel * signed weight, grown by the tap count
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned wt_w,
                                            input int unsigned k);
    return data_w + 1 + wt_w + $clog2(k * k);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Raster position counters, K-1 line buffers and the KxK sliding window.
// Window tap index is row*K + col, row 0 being the oldest image row.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned K      = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  logic [DATA_W-1:0]           i_data,
  output logic [K*K-1:0][DATA_W-1:0]  o_win,
  output logic                        o_win_done_c,
  output logic                        o_frame_end_c
);

  localparam int unsigned COL_W = clog2_min1(IMG_W);
  localparam int unsigned ROW_W = clog2_min1(IMG_H);

  logic [COL_W-1:0]          r_col;
  logic [ROW_W-1:0]          r_row;
  logic [DATA_W-1:0]         r_lb [K-1][IMG_W];
  logic [K*K-1:0][DATA_W-1:0] r_win;
  logic [K-1:0][DATA_W-1:0]  w_tap;
  logic                      w_col_end;
  logic                      w_row_end;

  assign w_col_end     = (r_col == COL_W'(IMG_W - 1));
  assign w_row_end     = (r_row == ROW_W'(IMG_H - 1));
  assign o_win_done_c  = i_push && (r_row >= ROW_W'(K - 1)) && (r_col >= COL_W'(K - 1));
  assign o_frame_end_c = w_col_end && w_row_end;
  assign o_win         = r_win;

  // Column of K pixels entering the window: buffered rows oldest first, then the new pixel
  always_comb begin : tap_sel
    w_tap = '0;
    for (int unsigned r = 0; r < K - 1; r++) begin
      w_tap[r] = r_lb[K-2-r][r_col];
    end
    w_tap[K-1] = i_data;
  end

  always_ff @(posedge clk or posedge rst) begin : lb_regs
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_win <= '0;
      for (int unsigned i = 0; i < K - 1; i++) begin
        for (int unsigned j = 0; j < IMG_W; j++) begin
          r_lb[i][j] <= '0;
        end
      end
    end else if (i_push) begin
      r_col <= w_col_end ? '0 : r_col + COL_W'(1);
      if (w_col_end) begin
        r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
      end
      // Line buffer 0 holds the previous row; older rows cascade down at the same column
      r_lb[0][r_col] <= i_data;
      for (int unsigned i = 1; i < K - 1; i++) begin
        r_lb[i][r_col] <= r_lb[i-1][r_col];
      end
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K - 1; c++) begin
          r_win[r*K+c] <= r_win[r*K+c+1];
        end
        r_win[r*K+K-1] <= w_tap[r];
      end
    end
  end

endmodule

// File: rtl/conv_layer_stream.sv
// Streaming KxK convolution over NUM_FILT filters with a run/MAC/emit handshake FSM.
// Weights are writable only between frames; results are rounded, shifted and saturated.
module conv_layer_stream
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned IMG_H      = 28,
  parameter int unsigned K          = 5,
  parameter int unsigned NUM_FILT   = 6,
  parameter int unsigned WT_W       = 8,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned FRAC_SHIFT = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [DATA_W-1:0]                         in_data,
  input  logic                                      wt_we,
  input  logic [clog2_min1(NUM_FILT*K*K)-1:0]       wt_addr,
  input  logic signed [WT_W-1:0]                    wt_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic signed [OUT_W-1:0]                   out_data,
  output logic [clog2_min1(NUM_FILT)-1:0]           out_chan,
  output logic                                      out_last,
  output logic                                      busy
);

  localparam int unsigned TAPS   = K * K;
  localparam int unsigned NUM_WT = NUM_FILT * TAPS;
  localparam int unsigned CHAN_W = clog2_min1(NUM_FILT);
  localparam int unsigned ACC_W  = acc_width(DATA_W, WT_W, K);
  localparam int unsigned EXT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic signed [ACC_W-1:0] RND =
    (FRAC_SHIFT == 0) ? '0 : (ACC_W'(1) << (FRAC_SHIFT - 1));
  localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'({(OUT_W - 1){1'b1}});
  localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;

  state_t                      r_state;
  logic                        r_mac_cnt;
  logic                        r_last_win;
  logic                        r_busy;
  logic                        r_in_ready;
  logic                        r_out_valid;
  logic                        r_out_last;
  logic signed [OUT_W-1:0]     r_out_data;
  logic [CHAN_W-1:0]           r_out_chan;
  logic signed [WT_W-1:0]      r_wt  [NUM_WT];
  logic signed [ACC_W-1:0]     r_acc [NUM_FILT];
  logic signed [OUT_W-1:0]     r_res [NUM_FILT];

  logic signed [ACC_W-1:0]     w_acc [NUM_FILT];
  logic signed [EXT_W-1:0]     w_shr [NUM_FILT];
  logic signed [OUT_W-1:0]     w_res [NUM_FILT];
  logic [TAPS-1:0][DATA_W-1:0] w_win;
  logic                        w_push;
  logic                        w_win_done;
  logic                        w_frame_end;
  logic                        w_last_chan;
  logic [CHAN_W-1:0]           w_next_chan;

  assign w_push      = in_valid && r_in_ready;
  assign w_last_chan = (r_out_chan == CHAN_W'(NUM_FILT - 1));
  assign w_next_chan = r_out_chan + CHAN_W'(1);

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

  conv_line_buffer #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K)
  ) u_line_buffer (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_data        (in_data),
    .o_win         (w_win),
    .o_win_done_c  (w_win_done),
    .o_frame_end_c (w_frame_end)
  );

  // Dot product of the window with every filter; pixels enter as non-negative signed values
  always_comb begin : mac_array
    logic signed [ACC_W-1:0] v_sum;
    v_sum = '0;
    for (int unsigned f = 0; f < NUM_FILT; f++) begin
      v_sum = '0;
      for (int unsigned t = 0; t < TAPS; t++) begin
        v_sum = v_sum + ACC_W'(signed'({1'b0, w_win[t]})) * ACC_W'(r_wt[f*TAPS+t]);
      end
      w_acc[f] = v_sum;
    end
  end

  // Round half up, arithmetic shift, then clamp into the signed output range
  always_comb begin : round_sat
    for (int unsigned f = 0; f < NUM_FILT; f++) begin
      w_shr[f] = EXT_W'((r_acc[f] + RND) >>> FRAC_SHIFT);
      if (w_shr[f] > OUT_MAX) begin
        w_res[f] = OUT_W'(OUT_MAX);
      end else if (w_shr[f] < OUT_MIN) begin
        w_res[f] = OUT_W'(OUT_MIN);
      end else begin
        w_res[f] = OUT_W'(w_shr[f]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : wt_regs
    if (rst) begin
      for (int unsigned i = 0; i < NUM_WT; i++) begin
        r_wt[i] <= '0;
      end
    end else if (wt_we && !r_busy && (32'(wt_addr) < NUM_WT)) begin
      r_wt[wt_addr] <= wt_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : fsm
    if (rst) begin
      r_state     <= ST_RUN;
      r_mac_cnt   <= 1'b0;
      r_last_win  <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      for (int unsigned f = 0; f < NUM_FILT; f++) begin
        r_acc[f] <= '0;
        r_res[f] <= '0;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_push) begin
            r_busy <= 1'b1;
            if (w_win_done) begin
              r_state    <= ST_MAC;
              r_mac_cnt  <= 1'b0;
              r_last_win <= w_frame_end;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_MAC: begin
          // Cycle 0 captures the accumulators, cycle 1 the saturated results
          if (!r_mac_cnt) begin
            r_mac_cnt <= 1'b1;
            for (int unsigned f = 0; f < NUM_FILT; f++) begin
              r_acc[f] <= w_acc[f];
            end
          end else begin
            for (int unsigned f = 0; f < NUM_FILT; f++) begin
              r_res[f] <= w_res[f];
            end
            r_state     <= ST_EMIT;
            r_out_valid <= 1'b1;
            r_out_chan  <= '0;
            r_out_data  <= w_res[0];
            r_out_last  <= r_last_win && (NUM_FILT == 1);
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (w_last_chan) begin
              r_state     <= ST_RUN;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
              if (r_last_win) begin
                r_busy <= 1'b0;
              end
            end else begin
              r_out_chan <= w_next_chan;
              r_out_data <= r_res[w_next_chan];
              r_out_last <= r_last_win && (w_next_chan == CHAN_W'(NUM_FILT - 1));
            end
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_stream.sv
// Directed bench for conv_layer_stream on a 5x5 image, 3x3 kernel, two filters.
module tb_conv_layer_stream;

  localparam int unsigned NBEATS = 18;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready, in_ready_s;
  logic [7:0]         in_data;
  logic               wt_we;
  logic [4:0]         wt_addr;
  logic signed [7:0]  wt_data;
  logic               out_valid, out_valid_s;
  logic               out_ready;
  logic signed [15:0] out_data, out_data_s;
  logic [0:0]         out_chan, out_chan_s;
  logic               out_last, out_last_s;
  logic               busy, busy_s;

  int checks = 0;
  int errors = 0;
  int wt_cfg [18];
  int q_data [$];
  int q_chan [$];
  int q_last [$];
  int qs_data [$];

  always #5 clk = ~clk;

  conv_layer_stream #(
    .DATA_W(8), .IMG_W(5), .IMG_H(5), .K(3), .NUM_FILT(2),
    .WT_W(8), .OUT_W(16), .FRAC_SHIFT(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_last(out_last), .busy(busy)
  );

  conv_layer_stream #(
    .DATA_W(8), .IMG_W(5), .IMG_H(5), .K(3), .NUM_FILT(2),
    .WT_W(8), .OUT_W(16), .FRAC_SHIFT(0)
  ) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_chan(out_chan_s), .out_last(out_last_s), .busy(busy_s)
  );

  // Beat collector: a beat transfers at the next rising edge when valid & ready
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_data.push_back(int'(out_data));
      q_chan.push_back(int'(out_chan));
      q_last.push_back(int'(out_last));
    end
    if (!rst && out_valid_s && out_ready) begin
      qs_data.push_back(int'(out_data_s));
    end
  end

  function automatic int centre(input int w);
    return (w / 3 + 1) * 5 + (w % 3 + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_chan.delete();
    q_last.delete();
    qs_data.delete();
  endtask

  task automatic write_wt(input int addr, input int val);
    wt_we   = 1'b1;
    wt_addr = 5'(addr);
    wt_data = 8'(val);
    step();
    wt_we   = 1'b0;
  endtask

  task automatic load_weights();
    for (int i = 0; i < 18; i++) write_wt(i, wt_cfg[i]);
  endtask

  task automatic set_filter_cfg();
    for (int i = 0; i < 18; i++) wt_cfg[i] = (i >= 9 || i == 4) ? 16 : 0;
  endtask

  // mode 0: ramp pixel = raster index; mode 1: constant 255
  task automatic send_pixels(input int first, input int n, input int mode);
    int budget;
    for (int i = first; i < first + n; i++) begin
      budget   = 0;
      in_valid = 1'b1;
      in_data  = (mode == 0) ? 8'(i) : 8'd255;
      @(negedge clk);
      while (!in_ready) begin
        budget++;
        if (budget > 300) begin
          checks++;
          errors++;
          $display("FAIL in_ready_timeout pixel %0d still not accepted after %0d cycles", i, budget);
          in_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    @(negedge clk);
    while (busy || out_valid) begin
      budget++;
      if (budget > 500) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout busy=%0b out_valid=%0b after %0d cycles", busy, out_valid, budget);
        break;
      end
      @(negedge clk);
    end
    step();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'sd0 ||
        out_chan !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b data=%0d chan=%0d last=%b busy=%b want 1 0 0 0 0 0",
               in_ready, out_valid, out_data, out_chan, out_last, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
  endtask

  task automatic test_zero_weights();
    clear_q();
    send_pixels(0, 25, 0);
    wait_idle();
    checks++;
    if (q_data.size() !== NBEATS) begin
      errors++;
      $display("FAIL zero_count got %0d beats want %0d", q_data.size(), NBEATS);
    end
    for (int b = 0; b < q_data.size() && b < NBEATS; b++) begin
      checks++;
      if (q_data[b] !== 0 || q_chan[b] !== b % 2 || q_last[b] !== int'(b == 17)) begin
        errors++;
        $display("FAIL zero_beat%0d got %0d/%0d/%0d want 0/%0d/%0d", b, q_data[b], q_chan[b], q_last[b], b % 2, int'(b == 17));
      end
    end
  endtask

  task automatic test_filter();
    time t0;
    int  want;
    set_filter_cfg();
    load_weights();
    clear_q();
    t0 = $time;
    send_pixels(0, 12, 0);
    checks++;
    if ($time - t0 != 120) begin
      errors++;
      $display("FAIL back_to_back took %0t want 120", $time - t0);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_midframe got %b want 1", busy);
    end
    send_pixels(12, 13, 0);
    wait_idle();
    checks++;
    if (q_data.size() !== NBEATS) begin
      errors++;
      $display("FAIL filter_count got %0d beats want %0d", q_data.size(), NBEATS);
    end
    for (int b = 0; b < q_data.size() && b < NBEATS; b++) begin
      want = (b % 2 == 0) ? centre(b / 2) : 9 * centre(b / 2);
      checks++;
      if (q_data[b] !== want || q_chan[b] !== b % 2 || q_last[b] !== int'(b == 17)) begin
        errors++;
        $display("FAIL filter_beat%0d got %0d/%0d/%0d want %0d/%0d/%0d", b, q_data[b], q_chan[b], q_last[b], want, b % 2, int'(b == 17));
      end
    end
  endtask

  task automatic test_rounding();
    int want;
    for (int i = 0; i < 18; i++) wt_cfg[i] = (i >= 9) ? -16 : ((i == 4) ? 1 : 0);
    load_weights();
    clear_q();
    send_pixels(0, 25, 0);
    wait_idle();
    checks++;
    if (q_data.size() !== NBEATS) begin
      errors++;
      $display("FAIL round_count got %0d beats want %0d", q_data.size(), NBEATS);
    end
    for (int b = 0; b < q_data.size() && b < NBEATS; b++) begin
      want = (b % 2 == 0) ? ((centre(b / 2) >= 8) ? 1 : 0) : -9 * centre(b / 2);
      checks++;
      if (q_data[b] !== want) begin
        errors++;
        $display("FAIL round_beat%0d got %0d want %0d", b, q_data[b], want);
      end
    end
  endtask

  task automatic test_saturation();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 18; i++) wt_cfg[i] = (pass == 0) ? 127 : -128;
      load_weights();
      clear_q();
      send_pixels(0, 25, 1);
      wait_idle();
      checks++;
      if (qs_data.size() !== NBEATS) begin
        errors++;
        $display("FAIL sat%0d_count got %0d beats want %0d", pass, qs_data.size(), NBEATS);
      end
      for (int b = 0; b < qs_data.size() && b < NBEATS; b++) begin
        checks++;
        if (qs_data[b] !== ((pass == 0) ? 32767 : -32768)) begin
          errors++;
          $display("FAIL sat%0d_beat%0d got %0d want %0d", pass, b, qs_data[b], (pass == 0) ? 32767 : -32768);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] hd;
    logic [0:0]         hc;
    logic               hl;
    int                 want;
    int                 budget;
    set_filter_cfg();
    load_weights();
    clear_q();
    out_ready = 1'b0;
    fork
      send_pixels(0, 25, 0);
      begin
        budget = 0;
        @(negedge clk);
        while (!out_valid && budget <= 300) begin
          budget++;
          @(negedge clk);
        end
        checks++;
        if (!out_valid) begin
          errors++;
          $display("FAIL stall_wait out_valid never rose within %0d cycles", budget);
        end else begin
          hd = out_data;
          hc = out_chan;
          hl = out_last;
          if (hd !== 16'sd6 || hc !== 1'b0 || hl !== 1'b0) begin
            errors++;
            $display("FAIL stall_first got %0d/%0d/%b want 6/0/0", hd, hc, hl);
          end
          for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_data !== hd || out_chan !== hc || out_last !== hl || out_valid !== 1'b1 || in_ready !== 1'b0) begin
              errors++;
              $display("FAIL stall_hold%0d got %0d/%0d/%b vld=%b rdy=%b want %0d/%0d/%b vld=1 rdy=0",
                       i, out_data, out_chan, out_last, out_valid, in_ready, hd, hc, hl);
            end
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_idle();
    checks++;
    if (q_data.size() !== NBEATS) begin
      errors++;
      $display("FAIL stall_count got %0d beats want %0d", q_data.size(), NBEATS);
    end
    for (int b = 0; b < q_data.size() && b < NBEATS; b++) begin
      want = (b % 2 == 0) ? centre(b / 2) : 9 * centre(b / 2);
      checks++;
      if (q_data[b] !== want || q_chan[b] !== b % 2 || q_last[b] !== int'(b == 17)) begin
        errors++;
        $display("FAIL stall_beat%0d got %0d/%0d/%0d want %0d/%0d/%0d", b, q_data[b], q_chan[b], q_last[b], want, b % 2, int'(b == 17));
      end
    end
  endtask

  task automatic test_reset_midframe();
    int want;
    int budget;
    send_pixels(0, 12, 0);
    rst = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got busy=%b rdy=%b vld=%b want 0 1 0", busy, in_ready, out_valid);
    end
    rst = 1'b0;
    step();
    set_filter_cfg();
    load_weights();
    clear_q();
    send_pixels(0, 25, 0);
    budget = 0;
    @(negedge clk);
    while (!(out_valid && out_last) && budget <= 300) begin
      budget++;
      @(negedge clk);
    end
    checks++;
    if (!(out_valid && out_last) || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_at_last got vld=%b last=%b busy=%b want 1 1 1", out_valid, out_last, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_fall got %b want 0", busy);
    end
    wait_idle();
    checks++;
    if (q_data.size() !== NBEATS) begin
      errors++;
      $display("FAIL midreset_count got %0d beats want %0d", q_data.size(), NBEATS);
    end
    for (int b = 0; b < q_data.size() && b < NBEATS; b++) begin
      want = (b % 2 == 0) ? centre(b / 2) : 9 * centre(b / 2);
      checks++;
      if (q_data[b] !== want || q_chan[b] !== b % 2 || q_last[b] !== int'(b == 17)) begin
        errors++;
        $display("FAIL midreset_beat%0d got %0d/%0d/%0d want %0d/%0d/%0d", b, q_data[b], q_chan[b], q_last[b], want, b % 2, int'(b == 17));
      end
    end
  endtask

  task automatic test_wt_busy();
    int want;
    clear_q();
    send_pixels(0, 3, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wt_busy_flag got %b want 1", busy);
    end
    write_wt(4, 100);
    send_pixels(3, 22, 0);
    wait_idle();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        write_wt(4, 32);
        clear_q();
        send_pixels(0, 25, 0);
        wait_idle();
      end
      checks++;
      if (q_data.size() !== NBEATS) begin
        errors++;
        $display("FAIL wt%0d_count got %0d beats want %0d", pass, q_data.size(), NBEATS);
      end
      for (int b = 0; b < q_data.size() && b < NBEATS; b++) begin
        want = (b % 2 == 1) ? 9 * centre(b / 2) : ((pass == 0) ? centre(b / 2) : 2 * centre(b / 2));
        checks++;
        if (q_data[b] !== want) begin
          errors++;
          $display("FAIL wt%0d_beat%0d got %0d want %0d", pass, b, q_data[b], want);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    wt_we     = 1'b0;
    wt_addr   = '0;
    wt_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_zero_weights();
    test_filter();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_reset_midframe();
    test_wt_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation exceeded 500000 time units");
    $fatal(1, "global timeout");
  end

endmodule
